// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: register map,
// CTRL bit positions and the all-dark segment pattern.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ADDR_DIGITS = 2'd0,
    ADDR_BLANK  = 2'd1,
    ADDR_CTRL   = 2'd2,
    ADDR_RSVD   = 2'd3
  } reg_addr_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_LZS = 1;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [1:0] CTRL_RST = 2'b01;

endpackage

// File: rtl/seg_scan_ctrl_dec7seg.sv
// Hex nibble to active-low 7-segment pattern for common-anode digits,
// bit0 = a through bit6 = g.
module dec7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a small store-path
// register file, per-digit blanking, leading-zero suppression and dead time.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [1:0]            rd_addr,
  output logic [31:0]           rd_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [DW-1:0]         digits_q, digits_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [3:0] sel_nib;
  logic       sel_blank;
  logic       sel_lz;
  logic       zero_run;
  logic       dark;
  logic       in_dead;
  logic       scan_en;
  logic [6:0] dec_seg;
  logic       wr_data_unused;

  assign wr_data_unused = &{1'b0, wr_data};
  assign scan_en        = ctrl_q[CTRL_EN];

  // Register file writes
  always_comb begin
    digits_d = digits_q;
    blank_d  = blank_q;
    ctrl_d   = ctrl_q;
    if (wr_en) begin
      case (wr_addr)
        ADDR_DIGITS: digits_d = wr_data[DW-1:0];
        ADDR_BLANK:  blank_d  = wr_data[NUM_DIGITS-1:0];
        ADDR_CTRL:   ctrl_d   = wr_data[1:0];
        default:     ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_DIGITS: rd_data[DW-1:0]         = digits_q;
      ADDR_BLANK:  rd_data[NUM_DIGITS-1:0] = blank_q;
      ADDR_CTRL:   rd_data[1:0]            = ctrl_q;
      default:     ;
    endcase
  end

  // Prescaler and digit index; both parked at zero while disabled
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (!scan_en) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Digit select; zero_run tracks whether every nibble from i upward is zero
  always_comb begin
    sel_nib   = '0;
    sel_blank = 1'b0;
    sel_lz    = 1'b0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (digits_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        sel_nib   = digits_q[4*i +: 4];
        sel_blank = blank_q[i];
        sel_lz    = zero_run && (i != 0);
      end
    end
  end

  dec7seg u_dec7seg (
    .nibble (sel_nib),
    .seg    (dec_seg)
  );

  assign dark    = sel_blank || (ctrl_q[CTRL_LZS] && sel_lz);
  assign in_dead = (presc_q < PW'(BLANK_CYC));

  // A dark digit keeps its anode driven; only the segments are blanked
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = '1;
    if (scan_en && !in_dead) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IW'(i));
      end
      if (!dark) seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      blank_q  <= '0;
      ctrl_q   <= CTRL_RST;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= '1;
    end else begin
      digits_q <= digits_d;
      blank_q  <= blank_d;
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
